// File: rtl/solver_pkg.sv
// Shared solver datapath definitions: default vector geometry and the
// unloader state encoding.
package solver_pkg;

   localparam int N_DEF  = 16;
   localparam int XW_DEF = 32;
   localparam int OW_DEF = 16;
   localparam int IDX_W  = $clog2(N_DEF);

   typedef enum logic {S_IDLE, S_DRAIN} state_t;

endpackage

// File: rtl/x_sat.sv
// Combinational signed XW-to-OW reduction on the unloader read path.
// X_UNLOADER_SAT_EN selects saturation; otherwise the low OW bits are kept.
module x_sat #(
   parameter int XW = 32,
   parameter int OW = 16
) (
   input  logic signed [XW-1:0] din,
   output logic signed [OW-1:0] dout
);

`ifdef X_UNLOADER_SAT_EN
   localparam logic signed [XW-1:0] MAXV = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [XW-1:0] MINV = {{(XW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   function automatic logic signed [OW-1:0] conv(input logic signed [XW-1:0] v);
      if (v > MAXV)
         conv = OW'(MAXV);
      else if (v < MINV)
         conv = OW'(MINV);
      else
         conv = OW'(v);
   endfunction
`else
   function automatic logic signed [OW-1:0] conv(input logic signed [XW-1:0] v);
      conv = OW'(v);
   endfunction
`endif

   assign dout = conv(din);

endmodule

// File: rtl/x_unloader.sv
// Captures the N solution values from the solver core and streams them out
// in index order over a valid/ready handshake. Build option: X_UNLOADER_SAT_EN.
module x_unloader
   import solver_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int XW = XW_DEF,
   parameter int OW = OW_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      x_wen,
   input  logic [$clog2(N)-1:0]      x_addr,
   input  logic signed [XW-1:0]      x_i,
   input  logic                      start_out,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic signed [OW-1:0]      x_o,
   output logic                      out_last,
   output logic                      busy,
   output logic                      out_done
);

   localparam int IW = $clog2(N);

   logic signed [XW-1:0] mem [N];
   state_t               state;
   logic [IW-1:0]        rd_idx;
   logic [IW-1:0]        nxt_idx;
   logic signed [XW-1:0] rd_x;
   logic signed [OW-1:0] conv_x;
   logic                 xfer;
   logic                 at_last;

   assign nxt_idx = rd_idx + 1'b1;
   assign xfer    = out_valid && out_ready;
   assign at_last = (rd_idx == IW'(N-1));

   // x_o is registered, so the converter always looks at the word to be shown
   // next cycle; a same-cycle write to entry 0 is forwarded into the first word.
   always_comb begin
      rd_x = mem[nxt_idx];
      if (state == S_IDLE)
         rd_x = (x_wen && x_addr == '0) ? x_i : mem[0];
   end

   x_sat #(.XW(XW), .OW(OW)) u_sat (
      .din  (rd_x),
      .dout (conv_x)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         rd_idx    <= '0;
         out_valid <= 1'b0;
         x_o       <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         out_done  <= 1'b0;
         for (int i = 0; i < N; i++)
            mem[i] <= '0;
      end else begin
         out_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (x_wen)
                  mem[x_addr] <= x_i;
               if (start_out) begin
                  state     <= S_DRAIN;
                  rd_idx    <= '0;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  x_o       <= conv_x;
                  out_last  <= (N == 1);
               end
            end
            S_DRAIN: begin
               if (xfer) begin
                  if (at_last) begin
                     state     <= S_IDLE;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     out_last  <= 1'b0;
                     x_o       <= '0;
                     out_done  <= 1'b1;
                  end else begin
                     rd_idx   <= nxt_idx;
                     x_o      <= conv_x;
                     out_last <= (nxt_idx == IW'(N-1));
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_x_unloader.sv
// Self-checking bench for x_unloader: queue-based stream model plus literal
// expectations for the directed scenarios. Honours X_UNLOADER_SAT_EN.
module tb_x_unloader;

   localparam int N  = 16;
   localparam int XW = 32;
   localparam int OW = 16;
   localparam int IW = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 x_wen = 1'b0;
   logic [IW-1:0]        x_addr = '0;
   logic signed [XW-1:0] x_i = '0;
   logic                 start_out = 1'b0;
   logic                 out_ready = 1'b0;
   logic                 out_valid;
   logic signed [OW-1:0] x_o;
   logic                 out_last;
   logic                 busy;
   logic                 out_done;

   x_unloader #(.N(N), .XW(XW), .OW(OW)) dut (
      .clk       (clk),
      .rst       (rst),
      .x_wen     (x_wen),
      .x_addr    (x_addr),
      .x_i       (x_i),
      .start_out (start_out),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .x_o       (x_o),
      .out_last  (out_last),
      .busy      (busy),
      .out_done  (out_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic longint conv(input longint v);
`ifdef X_UNLOADER_SAT_EN
      longint mx;
      longint mn;
      mx = (longint'(1) << (OW-1)) - 1;
      mn = -(longint'(1) << (OW-1));
      if (v > mx) return mx;
      if (v < mn) return mn;
      return v;
`else
      logic signed [OW-1:0] t;
      t = v[OW-1:0];
      return longint'(t);
`endif
   endfunction

   // Reference: storage array plus a queue of words still owed to the consumer.
   longint mmem [N];
   longint q [$];
   bit     exp_done = 1'b0;

   initial foreach (mmem[k]) mmem[k] = 0;

   always @(posedge clk) begin
      if (rst) begin
         foreach (mmem[k]) mmem[k] = 0;
         q.delete();
         exp_done = 1'b0;
      end else begin
         exp_done = 1'b0;
         if (q.size() == 0) begin
            if (x_wen) mmem[x_addr] = longint'(x_i);
            if (start_out)
               for (int k = 0; k < N; k++) q.push_back(conv(mmem[k]));
         end else if (out_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) exp_done = 1'b1;
         end
      end
   end

   bit     chk_en = 1'b0;
   longint rcv [$];
   bit     rlast [$];

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", longint'(out_valid), longint'(q.size() > 0));
         check("busy", longint'(busy), longint'(q.size() > 0));
         check("out_done", longint'(out_done), longint'(exp_done));
         if (q.size() > 0) begin
            check("x_o", longint'(x_o), q[0]);
            check("out_last", longint'(out_last), longint'(q.size() == 1));
         end else begin
            check("out_last_idle", longint'(out_last), 0);
         end
         if (out_valid && out_ready) begin
            rcv.push_back(longint'(x_o));
            rlast.push_back(out_last);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input int addr, input longint val);
      x_wen  = 1'b1;
      x_addr = IW'(addr);
      x_i    = XW'(val);
      tick();
      x_wen  = 1'b0;
   endtask

   task automatic pulse_start();
      start_out = 1'b1;
      tick();
      start_out = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (out_done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("drain_timeout", 0, 1);
   endtask

   longint e0, e1;
   bit     pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   initial begin
`ifdef X_UNLOADER_SAT_EN
      e0 = 32767;
      e1 = -32768;
`else
      e0 = 4464;
      e1 = -4464;
`endif

      // Reset
      rst = 1'b1;
      repeat (3) tick();
      check("rst_valid", longint'(out_valid), 0);
      check("rst_x_o", longint'(x_o), 0);
      check("rst_last", longint'(out_last), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_done", longint'(out_done), 0);
      rst = 1'b0;
      chk_en = 1'b1;

      // Fill and drain
      for (int k = 0; k < N; k++) write(k, k * 3);
      out_ready = 1'b1;
      rcv.delete(); rlast.delete();
      pulse_start();
      wait_done(40);
      check("fill_count", rcv.size(), 16);
      for (int k = 0; k < rcv.size(); k++) begin
         check("fill_word", rcv[k], k * 3);
         check("fill_last", longint'(rlast[k]), longint'(k == 15));
      end

      // Backpressure replay of the same vector
      rcv.delete(); rlast.delete();
      out_ready = 1'b0;
      pulse_start();
      for (int c = 0; c < 200 && !out_done; c++) begin
         out_ready = pat[c % 4];
         tick();
      end
      check("bp_done_seen", longint'(out_done), 1);
      check("bp_count", rcv.size(), 16);
      for (int k = 0; k < rcv.size(); k++) check("bp_word", rcv[k], k * 3);

      // Saturation / truncation
      out_ready = 1'b1;
      write(0, 70000);
      write(1, -70000);
      write(2, -5);
      rcv.delete();
      pulse_start();
      wait_done(40);
      check("conv_count", rcv.size(), 16);
      if (rcv.size() >= 3) begin
         check("conv_x0", rcv[0], e0);
         check("conv_x1", rcv[1], e1);
         check("conv_x2", rcv[2], -5);
      end

      // Write and start during DRAIN are ignored
      rcv.delete();
      pulse_start();
      tick();
      x_wen = 1'b1; x_addr = '0; x_i = 123; start_out = 1'b1;
      tick();
      x_wen = 1'b0; start_out = 1'b0;
      wait_done(40);
      check("ign_count", rcv.size(), 16);
      if (rcv.size() >= 1) check("ign_x0", rcv[0], e0);
      rcv.delete();
      pulse_start();
      wait_done(40);
      if (rcv.size() >= 1) check("replay_x0", rcv[0], e0);
      else check("replay_count", rcv.size(), 16);

      // Same-cycle write and start: the write lands in the stream
      rcv.delete();
      x_wen = 1'b1; x_addr = '0; x_i = -7; start_out = 1'b1;
      tick();
      x_wen = 1'b0; start_out = 1'b0;
      wait_done(40);
      if (rcv.size() >= 1) check("wr_start_x0", rcv[0], -7);
      else check("wr_start_count", rcv.size(), 16);

      // Randomised traffic
      for (int c = 0; c < 1500; c++) begin
         x_wen     = ($urandom % 2) == 0;
         x_addr    = IW'($urandom);
         x_i       = ($urandom % 2) ? XW'($urandom) : XW'(int'($urandom_range(0, 65535)) - 32768);
         start_out = ($urandom % 8) == 0;
         out_ready = ($urandom % 4) != 0;
         tick();
      end
      x_wen = 1'b0; start_out = 1'b0; out_ready = 1'b1;
      for (int c = 0; c < 40 && q.size() > 0; c++) tick();
      check("rand_drained", q.size(), 0);
      tick();

      // Reset mid-drain
      for (int k = 0; k < N; k++) write(k, 100 + k);
      rcv.delete();
      pulse_start();
      for (int c = 0; c < 40 && rcv.size() < 5; c++) tick();
      check("mid_xfers", rcv.size(), 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", longint'(out_valid), 0);
      check("mid_rst_x_o", longint'(x_o), 0);
      check("mid_rst_last", longint'(out_last), 0);
      check("mid_rst_busy", longint'(busy), 0);
      check("mid_rst_done", longint'(out_done), 0);
      @(posedge clk); #1;
      rcv.delete();
      pulse_start();
      wait_done(40);
      check("zero_count", rcv.size(), 16);
      for (int k = 0; k < rcv.size(); k++) check("zero_word", rcv[k], 0);

      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/x_unloader.md
# x_unloader

Read-side counterpart of the serial b-vector loader in the solver datapath. Captures the 16 solution values x[0..15] written by the iteration engine, then on command streams them out, one per handshake, in index order x[0] first, with a valid/ready handshake and an end-of-vector marker. It sits between the solver core and the result port of the top level, so the core can finish its final iteration without waiting for the consumer.

## Interface
- N, default 16: vector length, power of two; index width is log2(N).
- XW, default 32: width of the internal x values written by the core, signed.
- OW, default 16: width of the streamed output word, signed; OW <= XW.
- clk  in  1: single clock; all state updates on its rising edge.
- rst  in  1: synchronous, active-high reset.
- x_wen  in  1: write strobe from the core.
- x_addr  in  log2(N): index of the x value being written.
- x_i  in  XW: signed x value.
- start_out  in  1: one-cycle pulse that begins streaming.
- out_ready  in  1: consumer accepts the current word.
- out_valid  out  1: x_o holds a valid word.
- x_o  out  OW: signed output word.
- out_last  out  1: high together with out_valid on the word for index N-1.
- busy  out  1: high while in the DRAIN state.
- out_done  out  1: one-cycle pulse after the final transfer.

## Operation
- Storage: N registers of XW bits, signed. Reset clears all of them to 0.
- States:
  - IDLE: accepts writes; this is the reset state.
  - DRAIN: streams the stored values out.
- IDLE:
  - x_wen=1 writes x_i into entry x_addr. A later write to the same index overwrites the earlier one.
  - start_out=1 moves to DRAIN and sets rd_idx=0.
  - If x_wen and start_out are high in the same cycle, the write takes effect first, so the stream includes it.
- DRAIN:
  - out_valid=1 and x_o=conv(x[rd_idx]); out_last=(rd_idx==N-1).
  - A transfer is a cycle with out_valid&&out_ready.
  - On a transfer with rd_idx<N-1: rd_idx increments and the next word appears in the following cycle, with no bubble.
  - On the transfer with rd_idx==N-1: return to IDLE. In the next cycle out_valid=0 and out_done=1.
  - x_wen is ignored and storage does not change. start_out is ignored.
  - While out_ready=0, x_o, out_last and rd_idx hold stable.
- Storage is not cleared after draining. A second start_out replays the same vector.
- rst in any state, including mid-DRAIN: next cycle is IDLE, all outputs are 0 and storage is cleared.
- conv(): XW-to-OW reduction, chosen at compile time (see Configuration).

## Timing
- Reset values: out_valid=0, x_o=0, out_last=0, busy=0, out_done=0.
- x_o, out_valid, out_last and busy are registered outputs.
- Write latency: a write in cycle t is visible to a start_out in cycle t, and to any later one.
- Start latency: start_out in cycle t gives out_valid=1 with x[0] in cycle t+1.
- Throughput: with out_ready held high, N words in N consecutive cycles, and out_done at cycle t+N+1.
- busy equals out_valid. out_done never overlaps out_valid.

## Configuration
- Macro: X_UNLOADER_SAT_EN.
- Defined: conv() saturates the signed value to the range [-2^(OW-1), 2^(OW-1)-1].
- Undefined: conv() truncates, taking x[OW-1:0] with no overflow check.

## Structure
- Shared package (solver_pkg) holds:
  - N, XW and OW defaults;
  - index width constant;
  - state enum {S_IDLE, S_DRAIN}.
- Sub-module x_sat: combinational signed XW-to-OW converter. It contains the macro-selected saturate/truncate logic and is instantiated once on the read path.

## Test plan
- Fill and drain:
  - Stimulus: write x[k]=k*3 for k=0..15, pulse start_out, out_ready held high.
  - Required response: 16 consecutive words 0,3,...,45; out_last only on 45; out_done one cycle after.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1,... during the drain.
  - Required response: each word held stable while out_ready=0; order preserved; exactly 16 transfers.
- Saturation, with X_UNLOADER_SAT_EN:
  - Stimulus: write x[0]=70000, x[1]=-70000, x[2]=-5.
  - Required response: 32767, -32768, -5.
- Truncation, without the macro:
  - Stimulus: same writes as the saturation test.
  - Required response: x[0] streams as 4464 (0x1170).
- Ignored events:
  - Stimulus: x_wen to index 0 and start_out during DRAIN.
  - Required response: stream unchanged. A replay via a second start_out yields the original x[0].
- Reset mid-drain:
  - Stimulus: assert rst after 5 transfers, then pulse start_out.
  - Required response: outputs 0 in the cycle after rst; the replay streams all zeros.
